// File: rtl/ascii_stream_fifo.sv
// Character stream FIFO between the inference engine and the MicroBlaze GPIO.
// New characters are captured when generate_count changes; software pops one per ack toggle.
module ascii_stream_fifo #(
  parameter int DATA_W  = 8,
  parameter int COUNT_W = 12,
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               execute,
  input  logic [DATA_W-1:0]  generated_ascii,
  input  logic [COUNT_W-1:0] generate_count,
  input  logic               generate_complete,
  input  logic               gpio_ack_i,
  output logic [31:0]        gpio_char_o,
  output logic [AW:0]        fifo_level,
  output logic               overflow
);

  localparam int EW = COUNT_W + DATA_W;

  logic [EW-1:0]      r_mem [DEPTH];
  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;
  logic [COUNT_W-1:0] r_last_count;
  logic               r_exec_q;
  logic               r_ack_q;
  logic               r_done;
  logic               r_overflow;
  logic [31:0]        r_gpio_word;

  logic               w_empty;
  logic               w_full;
  logic               w_flush;
  logic               w_push_req;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               w_skip;
  logic               w_done_set;
  logic [EW-1:0]      w_head;
  logic [31:0]        w_word_nxt;

  // Per-cycle decode of flush/push/pop and the next GPIO word from current state.
  always_comb begin
    w_empty    = (r_wr_ptr == r_rd_ptr);
    w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_flush    = execute & ~r_exec_q;
    w_push_req = (generate_count != r_last_count);
    w_pop      = (gpio_ack_i != r_ack_q) && !w_empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept the push.
    w_push     = w_push_req && (!w_full || w_pop);
    w_drop     = w_push_req && w_full && !w_pop;
    w_skip     = w_push_req && (generate_count != (r_last_count + {{(COUNT_W-1){1'b0}}, 1'b1}));
    w_done_set = generate_complete && w_empty && !w_push_req;
    w_head     = r_mem[r_rd_ptr[AW-1:0]];
    if (w_empty) begin
      w_word_nxt = {1'b0, r_done, r_overflow, 29'd0};
    end else begin
      w_word_nxt = {1'b1, r_done, r_overflow, 1'b0, w_head[EW-1:DATA_W], 8'h00, w_head[DATA_W-1:0]};
    end
  end

  // Control state: pointers, edge detectors, sticky flags and the registered GPIO word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= {(AW+1){1'b0}};
      r_rd_ptr     <= {(AW+1){1'b0}};
      r_last_count <= {COUNT_W{1'b0}};
      r_exec_q     <= 1'b0;
      r_ack_q      <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_gpio_word  <= 32'd0;
    end else begin
      r_exec_q    <= execute;
      r_ack_q     <= gpio_ack_i;
      r_gpio_word <= w_word_nxt;
      if (w_flush) begin
        r_wr_ptr     <= {(AW+1){1'b0}};
        r_rd_ptr     <= {(AW+1){1'b0}};
        r_last_count <= {COUNT_W{1'b0}};
        r_overflow   <= 1'b0;
        r_done       <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
        if (w_push_req) begin
          r_last_count <= generate_count;
        end
        if (w_drop || w_skip) begin
          r_overflow <= 1'b1;
        end
        if (w_done_set) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  // Storage write; contents are only observed through valid head entries, so no reset.
  always_ff @(posedge clk) begin
    if (w_push && !w_flush) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {generate_count, generated_ascii};
    end
  end

  assign gpio_char_o = r_gpio_word;
  assign fifo_level  = r_wr_ptr - r_rd_ptr;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_ascii_stream_fifo.sv
// Directed bench for ascii_stream_fifo: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_ascii_stream_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        execute;
  logic [7:0]  generated_ascii;
  logic [11:0] generate_count;
  logic        generate_complete;
  logic        gpio_ack_i;
  logic [31:0] gpio_char_o;
  logic [4:0]  fifo_level;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [19:0] m_q[$];
  logic        m_ovf, m_done, m_execq, m_ackq;
  logic [11:0] m_last;
  logic [31:0] m_word;

  always #5 clk = ~clk;

  ascii_stream_fifo dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .execute          (execute),
    .generated_ascii  (generated_ascii),
    .generate_count   (generate_count),
    .generate_complete(generate_complete),
    .gpio_ack_i       (gpio_ack_i),
    .gpio_char_o      (gpio_char_o),
    .fifo_level       (fifo_level),
    .overflow         (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf   = 1'b0;
    m_done  = 1'b0;
    m_execq = 1'b0;
    m_ackq  = 1'b0;
    m_last  = 12'd0;
    m_word  = 32'd0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [31:0] nw;
    bit          push_req;
    if (m_q.size() == 0) nw = {1'b0, m_done, m_ovf, 29'd0};
    else nw = {1'b1, m_done, m_ovf, 1'b0, m_q[0][19:8], 8'h00, m_q[0][7:0]};
    if (execute && !m_execq) begin
      m_q.delete();
      m_last = 12'd0;
      m_ovf  = 1'b0;
      m_done = 1'b0;
    end else begin
      push_req = (generate_count != m_last);
      if (generate_complete && m_q.size() == 0 && !push_req) m_done = 1'b1;
      if (gpio_ack_i != m_ackq && m_q.size() > 0) void'(m_q.pop_front());
      if (push_req) begin
        if (m_q.size() < DEPTH) m_q.push_back({generate_count, generated_ascii});
        else m_ovf = 1'b1;
        if (generate_count != 12'(m_last + 12'd1)) m_ovf = 1'b1;
        m_last = generate_count;
      end
    end
    m_ackq  = gpio_ack_i;
    m_execq = execute;
    m_word  = nw;
  endtask

  // One clock: update model, let the edge happen, then compare every output.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("gpio_char_o", gpio_char_o, m_word);
    chk("fifo_level", {27'd0, fifo_level}, 32'(m_q.size()));
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  task automatic push(input logic [11:0] c, input logic [7:0] a);
    generate_count  = c;
    generated_ascii = a;
    cyc();
  endtask

  task automatic flush();
    execute = 1'b0;
    cyc();
    execute = 1'b1;
    cyc();
  endtask

  initial begin
    reset_n = 1'b1; execute = 1'b0; generated_ascii = 8'd0; generate_count = 12'd0;
    generate_complete = 1'b0; gpio_ack_i = 1'b0;
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("reset_gpio", gpio_char_o, 32'd0);
    chk("reset_level", {27'd0, fifo_level}, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    cyc();

    // 1: "Hi!" into a fresh run
    execute = 1'b1; cyc();
    push(12'd1, 8'h48); push(12'd2, 8'h69); push(12'd3, 8'h21);
    cyc();
    chk("t1_head", gpio_char_o, 32'h8001_0048);
    chk("t1_level", {27'd0, fifo_level}, 32'd3);

    // 2: pop three times, then completion
    gpio_ack_i = 1'b1; cyc(); cyc();
    chk("t2_pop1", gpio_char_o, 32'h8002_0069);
    gpio_ack_i = 1'b0; cyc(); cyc();
    chk("t2_pop2", gpio_char_o, 32'h8003_0021);
    gpio_ack_i = 1'b1; cyc(); cyc();
    chk("t2_pop3", gpio_char_o, 32'h0000_0000);
    generate_complete = 1'b1; cyc(); cyc();
    chk("t2_done", gpio_char_o, 32'h4000_0000);
    chk("t2_level", {27'd0, fifo_level}, 32'd0);
    generate_complete = 1'b0;

    // 3: 17 pushes into 16 entries
    flush();
    for (int i = 1; i <= 17; i++) push(12'(i), 8'(8'h40 + i));
    cyc();
    chk("t3_level", {27'd0, fifo_level}, 32'd16);
    chk("t3_ovf", {31'd0, overflow}, 32'd1);
    chk("t3_head", gpio_char_o, 32'hA001_0041);

    // 4: full FIFO, push and pop together
    flush();
    for (int i = 1; i <= 16; i++) push(12'(i), 8'(8'h40 + i));
    gpio_ack_i = 1'b0;
    push(12'd17, 8'h51);
    cyc();
    chk("t4_level", {27'd0, fifo_level}, 32'd16);
    chk("t4_ovf", {31'd0, overflow}, 32'd0);
    chk("t4_head", gpio_char_o, 32'h8002_0042);

    // 5: flush wins over ack and push in the same cycle
    flush();
    for (int i = 1; i <= 5; i++) push(12'(i), 8'(8'h30 + i));
    execute = 1'b0; cyc();
    execute = 1'b1; gpio_ack_i = 1'b1; push(12'd6, 8'h36);
    chk("t5_level", {27'd0, fifo_level}, 32'd0);
    chk("t5_ovf", {31'd0, overflow}, 32'd0);
    push(12'd0, 8'h00);
    chk("t5_gpio", gpio_char_o, 32'd0);
    chk("t5_level2", {27'd0, fifo_level}, 32'd0);

    // 6: skipped count, then asynchronous reset
    for (int i = 1; i <= 4; i++) push(12'(i), 8'(8'h30 + i));
    push(12'd6, 8'h36);
    chk("t6_ovf", {31'd0, overflow}, 32'd1);
    chk("t6_level", {27'd0, fifo_level}, 32'd5);
    for (int i = 0; i < 4; i++) begin
      gpio_ack_i = ~gpio_ack_i; cyc(); cyc();
    end
    chk("t6_head", gpio_char_o, 32'hA006_0036);
    #2;
    reset_n = 1'b0; gpio_ack_i = 1'b0; execute = 1'b0;
    #1;
    chk("t6_rst_gpio", gpio_char_o, 32'd0);
    chk("t6_rst_level", {27'd0, fifo_level}, 32'd0);
    chk("t6_rst_ovf", {31'd0, overflow}, 32'd0);
    model_reset();
    generate_count = 12'd0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
